mod_demod: RTL and testbench
============================

# mod_demod

Loopback modem: captures a 21-bit word, BPSK-modulates it MSB-first into a signed sample stream, demodulates that stream with an integrate-and-dump receiver, and reassembles the recovered word. It is the top-level link-integrity block of the modem datapath. In normal operation `demod_out` must reproduce `mod_in` after a fixed frame latency. The exposed sample stream serves as a probe point for later channel insertion.

## Interface
- `WIDTH`, default 21: word width in bits.
- `SPS`, default 4: samples per bit, ≥2.
- `AMP`, default 64: symbol amplitude, signed 8-bit, >0.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mod_in`  in  WIDTH: word to transmit; sampled only at frame start.
- `mod_sample`  out  8 (signed): registered modulator output.
- `demod_out`  out  WIDTH: last fully recovered word; held between updates.
- `demod_valid`  out  1: one-cycle pulse when `demod_out` updates.

## Operation
- FRAME = WIDTH*SPS clock cycles (84 at defaults). Frames run back-to-back, with no idle gap.
- Transmitter:
  - At each frame-start edge, copy `mod_in` into the tx shift register.
  - Bit index i=0 is the MSB. Each bit is held for SPS cycles.
  - Mapping: bit 1 → +AMP, bit 0 → −AMP.
  - `mod_sample` is registered and is 0 only while in reset.
- Receiver:
  - Signed accumulator of width 8+clog2(SPS)+1 sums the SPS samples of each bit.
  - On the last sample of a bit, decision = (acc + sample) ≥ 0. Clear the accumulator in the same cycle.
  - Shift the decision into the rx register LSB, so the MSB arrives first.
  - After WIDTH decisions, load the rx register into `demod_out` and pulse `demod_valid`.
- Boundary rules:
  - Changes on `mod_in` during a frame are ignored until the next frame-start edge.
  - A zero accumulator sum decides 1.
  - The rx bit counter wraps WIDTH−1 → 0 and the sample counter wraps SPS−1 → 0, with no lost cycle.
  - Frame N+1 transmission overlaps the last pipeline stages of frame N. `demod_out` must never contain a mix of two frames.

## Timing
- Reset values:
  - `mod_sample`=0, `demod_out`=0, `demod_valid`=0.
  - Accumulator, counters and shift registers cleared.
- Assertion of `rst_n` at any time, including mid-frame, aborts the frame immediately.
- The first frame-start edge is the first rising `clk` edge after `rst_n` deasserts (E0). Subsequent starts are at E0+k*FRAME.
- `mod_sample` for bit i, sample j is valid after edge E0+1+i*SPS+j.
- The receiver consumes each sample on the following edge.
- `demod_out`/`demod_valid` update at edge E0+FRAME+2, i.e. a fixed latency of FRAME+2 cycles from capture.
- `demod_valid` is high for exactly one cycle per frame.
- No back-pressure and no handshake. Throughput is one word per FRAME cycles.

## Structure
- Package `mod_demod_pkg`:
  - Default constants WIDTH, SPS, AMP.
  - `typedef logic signed [7:0] sample_t`.
  - Accumulator width constant.
- Sub-module `bpsk_demod`: integrate-and-dump accumulator, sample/bit counters, decision logic and rx shift register. It has inputs `clk`, `rst_n`, the sample stream and a frame-start strobe, and outputs the word plus the valid pulse.
- Transmitter and frame counter live in the top-level module.

## Test plan
- Reset held, then released with `mod_in`=0x133333 (100110011001100110011b):
  - All outputs 0 during reset.
  - `demod_valid` pulses at E0+86 with `demod_out`=0x133333.
- Consecutive frames 0x0CCCCC, 0x1FF800, 0x0003FF, each applied before its frame start:
  - Each is reproduced exactly, 84 cycles apart.
  - One valid pulse per frame.
- `mod_in` toggled mid-frame:
  - Current frame's `demod_out` still equals the value captured at its frame start.
- Probe `mod_sample` for 0x1FF800:
  - First 40 samples are +64.
  - Next 44 samples are −64.
- `rst_n` pulsed low at cycle 40 of a frame:
  - `demod_out`=0 and `demod_valid`=0 immediately.
  - Next valid pulse occurs FRAME+2 cycles after release and carries the new capture.
- All-ones 0x1FFFFF and all-zeros 0x000000 are recovered exactly, covering the accumulator sign extremes.

Source files
------------

// File: rtl/mod_demod_pkg.sv
// Shared constants and types for the BPSK loopback modem.
package mod_demod_pkg;

    localparam int DEF_WIDTH = 21;
    localparam int DEF_SPS   = 4;
    localparam int DEF_AMP   = 64;

    typedef logic signed [7:0] sample_t;

    // Sum of SPS 8-bit samples plus one guard bit.
    function automatic int acc_width(input int sps);
        return 8 + $clog2(sps) + 1;
    endfunction

    localparam int DEF_ACC_W = 8 + $clog2(DEF_SPS) + 1;

endpackage

// File: rtl/bpsk_demod.sv
// Integrate-and-dump BPSK receiver: one decision per SPS samples, MSB-first word assembly.
module bpsk_demod
    import mod_demod_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SPS   = DEF_SPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sample_t          sample,
    input  logic             sof,
    output logic [WIDTH-1:0] word,
    output logic             valid
);

    localparam int ACC_W  = acc_width(SPS);
    localparam int SCNT_W = $clog2(SPS);
    localparam int BCNT_W = $clog2(WIDTH);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_eff;
    logic signed [ACC_W-1:0] sum;
    logic [SCNT_W-1:0]       scnt;
    logic [SCNT_W-1:0]       s_eff;
    logic [BCNT_W-1:0]       bcnt;
    logic [BCNT_W-1:0]       b_eff;
    logic [WIDTH-1:0]        rx_sr;
    logic                    load_q;
    logic                    last_sample;
    logic                    last_bit;

    // sof marks sample 0 of bit 0; it re-aligns the counters every frame.
    always_comb begin
        s_eff       = sof ? '0 : scnt;
        b_eff       = sof ? '0 : bcnt;
        acc_eff     = sof ? '0 : acc;
        sum         = acc_eff + {{(ACC_W-8){sample[7]}}, sample};
        last_sample = (s_eff == SCNT_W'(SPS-1));
        last_bit    = (b_eff == BCNT_W'(WIDTH-1));
    end

    // valid is a single-cycle pulse with no ready: word is only loaded from a
    // complete rx_sr, one cycle after the final decision of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            scnt   <= '0;
            bcnt   <= '0;
            rx_sr  <= '0;
            load_q <= 1'b0;
            word   <= '0;
            valid  <= 1'b0;
        end else begin
            valid  <= load_q;
            load_q <= 1'b0;
            if (load_q) begin
                word <= rx_sr;
            end
            if (last_sample) begin
                rx_sr <= {rx_sr[WIDTH-2:0], ~sum[ACC_W-1]};
                acc   <= '0;
                scnt  <= '0;
                if (last_bit) begin
                    bcnt   <= '0;
                    load_q <= 1'b1;
                end else begin
                    bcnt <= b_eff + 1'b1;
                end
            end else begin
                acc  <= sum;
                scnt <= s_eff + 1'b1;
                bcnt <= b_eff;
            end
        end
    end

endmodule

// File: rtl/mod_demod.sv
// Loopback modem top: frame counter and BPSK transmitter feeding the integrate-and-dump receiver.
module mod_demod
    import mod_demod_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SPS   = DEF_SPS,
    parameter int AMP   = DEF_AMP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  mod_in,
    output logic signed [7:0] mod_sample,
    output logic [WIDTH-1:0]  demod_out,
    output logic              demod_valid
);

    localparam int FRAME  = WIDTH * SPS;
    localparam int FCNT_W = $clog2(FRAME);
    localparam int SCNT_W = $clog2(SPS);
    localparam sample_t POS = sample_t'(AMP);
    localparam sample_t NEG = sample_t'(-AMP);

    logic [FCNT_W-1:0] fcnt;
    logic [SCNT_W-1:0] tx_scnt;
    logic [WIDTH-1:0]  tx_sr;
    logic              frame_start;
    logic              start_q;
    logic              sof_q;

    assign frame_start = (fcnt == '0);

    // sof_q is delayed twice so it lines up with sample 0 on mod_sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt       <= '0;
            tx_scnt    <= '0;
            tx_sr      <= '0;
            start_q    <= 1'b0;
            sof_q      <= 1'b0;
            mod_sample <= '0;
        end else begin
            start_q    <= frame_start;
            sof_q      <= start_q;
            mod_sample <= tx_sr[WIDTH-1] ? POS : NEG;
            fcnt       <= (fcnt == FCNT_W'(FRAME-1)) ? '0 : fcnt + 1'b1;
            tx_scnt    <= (tx_scnt == SCNT_W'(SPS-1)) ? '0 : tx_scnt + 1'b1;
            if (frame_start) begin
                tx_sr <= mod_in;
            end else if (tx_scnt == '0) begin
                tx_sr <= tx_sr << 1;
            end
        end
    end

    bpsk_demod #(
        .WIDTH(WIDTH),
        .SPS  (SPS)
    ) u_demod (
        .clk   (clk),
        .rst_n (rst_n),
        .sample(mod_sample),
        .sof   (sof_q),
        .word  (demod_out),
        .valid (demod_valid)
    );

endmodule

// File: tb/tb_mod_demod.sv
// Directed bench for mod_demod: table of back-to-back frames, sample probe, mid-frame reset.
module tb_mod_demod;
    import mod_demod_pkg::*;

    localparam int WIDTH = 21;
    localparam int SPS   = 4;
    localparam int FRAME = WIDTH * SPS;
    localparam int LAT   = FRAME + 2;
    localparam int NV    = 6;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] exp_out;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  mod_in = '0;
    logic signed [7:0] mod_sample;
    logic [WIDTH-1:0]  demod_out;
    logic              demod_valid;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NV];
    logic [WIDTH-1:0] exp_q[$];

    mod_demod dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mod_in     (mod_in),
        .mod_sample (mod_sample),
        .demod_out  (demod_out),
        .demod_valid(demod_valid)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int f, o, t, tf, bi;
        logic exp_v;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] e;
        logic signed [7:0] exp_s;

        vecs[0] = '{21'h133333, 21'h133333};
        vecs[1] = '{21'h0CCCCC, 21'h0CCCCC};
        vecs[2] = '{21'h1FF800, 21'h1FF800};
        vecs[3] = '{21'h0003FF, 21'h0003FF};
        vecs[4] = '{21'h000000, 21'h000000};
        vecs[5] = '{21'h1FFFFF, 21'h1FFFFF};

        repeat (3) @(posedge clk);
        #1;
        check("reset mod_sample", 32'(mod_sample), 32'd0);
        check("reset demod_out", 32'(demod_out), 32'd0);
        check("reset demod_valid", 32'(demod_valid), 32'd0);

        @(negedge clk);
        mod_in = vecs[0].word;
        rst_n  = 1'b1;

        // c indexes edges after E0 (the first edge after release)
        for (int c = 0; c <= (NV-1)*FRAME + LAT; c++) begin
            f = c / FRAME;
            o = c % FRAME;
            if (o == 0 && f < NV) begin
                mod_in = vecs[f].word;
                exp_q.push_back(vecs[f].exp_out);
            end else if (o == 40 && f < NV) begin
                mod_in = ~vecs[f].word;
            end
            @(posedge clk);
            #1;
            exp_v = (c >= LAT) && ((c - LAT) % FRAME == 0);
            check("demod_valid", 32'(demod_valid), 32'(exp_v));
            if (exp_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL demod_out: valid with empty expected queue at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    check("demod_out", 32'(demod_out), 32'(e));
                end
            end
            if (c >= 1) begin
                t  = c - 1;
                tf = t / FRAME;
                if (tf < NV) begin
                    bi    = (t % FRAME) / SPS;
                    w     = vecs[tf].word;
                    exp_s = w[WIDTH-1-bi] ? 8'sd64 : -8'sd64;
                    check("mod_sample", 32'(mod_sample), 32'(exp_s));
                end
            end
        end
        check("queue drained", 32'(exp_q.size()), 32'd0);

        // now at offset 2 of the next frame; advance to offset 40
        repeat (38) @(posedge clk);
        #1;
        check("held demod_out", 32'(demod_out), 32'h1FFFFF);
        rst_n = 1'b0;
        #1;
        check("midreset mod_sample", 32'(mod_sample), 32'd0);
        check("midreset demod_out", 32'(demod_out), 32'd0);
        check("midreset demod_valid", 32'(demod_valid), 32'd0);

        @(negedge clk);
        mod_in = 21'h0AAAAA;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= LAT + 2; c++) begin
            @(posedge clk);
            #1;
            check("post-reset valid", 32'(demod_valid), 32'(c == LAT));
            if (c == LAT - 1) check("post-reset stale", 32'(demod_out), 32'd0);
            if (c == LAT) check("post-reset demod_out", 32'(demod_out), 32'h0AAAAA);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
